// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall controller driven by a shift register of in-flight destinations.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/forward event counters.
module fwd_hazard_unit #(
  parameter int NUM_SRC    = 2,
  parameter int FWD_DEPTH  = 2,
  parameter int LOAD_READY = 1,
  localparam int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid_ip,
  input  logic [5*NUM_SRC-1:0]     id_src_ip,
  input  logic [NUM_SRC-1:0]       id_src_used_ip,
  input  logic [4:0]               id_dest_ip,
  input  logic                     id_wen_ip,
  input  logic                     id_is_load_ip,
  input  logic                     flush_ip,
  input  logic                     ext_stall_ip,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]              stall_cnt_op,
  output logic [31:0]              fwd_cnt_op,
`endif
  output logic [SEL_W*NUM_SRC-1:0] fwd_sel_op,
  output logic                     stall_op
);

  logic [FWD_DEPTH-1:0]      vld_q;
  logic [FWD_DEPTH-1:0][4:0] dest_q;
  logic [FWD_DEPTH-1:0]      load_q;

  logic [SEL_W*NUM_SRC-1:0]  sel_d;
  logic [NUM_SRC-1:0]        hz_d;
  logic                      found;
  logic                      advance;
  logic                      ins_vld;

  // Scan youngest-first so the nearest producer wins; a too-young load blocks older matches too.
  always_comb begin
    sel_d = '0;
    hz_d  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      found = 1'b0;
      for (int k = 0; k < FWD_DEPTH; k++) begin
        if (!found && id_src_used_ip[i] && vld_q[k] &&
            dest_q[k] == id_src_ip[5*i +: 5] && id_src_ip[5*i +: 5] != 5'd0) begin
          found = 1'b1;
          if (load_q[k] && k < LOAD_READY) begin
            hz_d[i] = 1'b1;
          end else begin
            sel_d[SEL_W*i +: SEL_W] = SEL_W'(k + 1);
          end
        end
      end
    end
  end

  assign fwd_sel_op = sel_d;
  assign stall_op   = id_valid_ip & (|hz_d);
  assign advance    = ~ext_stall_ip;
  assign ins_vld    = id_valid_ip & id_wen_ip & ~stall_op & ~flush_ip & (id_dest_ip != 5'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q  <= '0;
      dest_q <= '0;
      load_q <= '0;
    end else if (advance) begin
      vld_q[0]  <= ins_vld;
      dest_q[0] <= id_dest_ip;
      load_q[0] <= id_is_load_ip;
      for (int k = 1; k < FWD_DEPTH; k++) begin
        vld_q[k]  <= vld_q[k-1];
        dest_q[k] <= dest_q[k-1];
        load_q[k] <= load_q[k-1];
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] fwd_cnt_q;
  logic        fwd_evt;

  assign fwd_evt = advance & id_valid_ip & ~stall_op & ~flush_ip & (|sel_d);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (stall_op && !ext_stall_ip && stall_cnt_q != 32'hFFFF_FFFF)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (fwd_evt && fwd_cnt_q != 32'hFFFF_FFFF)
        fwd_cnt_q <= fwd_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_op = stall_cnt_q;
  assign fwd_cnt_op   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed-vector scoreboard bench for fwd_hazard_unit: default instance plus a 3-source, depth-3 instance.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [14:0] src_bus;
  logic [2:0]  used;
  logic [4:0]  dest;
  logic        wen, is_load, flush, ext_stall;

  logic [3:0]  sel0;
  logic        stall0;
  logic [5:0]  sel1;
  logic        stall1;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] scnt0, fcnt0, scnt1, fcnt1;
`endif

  always #5 clk = ~clk;

  fwd_hazard_unit u0 (
    .clk(clk), .reset(rst_n), .id_valid_ip(id_valid), .id_src_ip(src_bus[9:0]),
    .id_src_used_ip(used[1:0]), .id_dest_ip(dest), .id_wen_ip(wen), .id_is_load_ip(is_load),
    .flush_ip(flush), .ext_stall_ip(ext_stall),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cnt_op(scnt0), .fwd_cnt_op(fcnt0),
`endif
    .fwd_sel_op(sel0), .stall_op(stall0)
  );

  fwd_hazard_unit #(.NUM_SRC(3), .FWD_DEPTH(3), .LOAD_READY(2)) u1 (
    .clk(clk), .reset(rst_n), .id_valid_ip(id_valid), .id_src_ip(src_bus),
    .id_src_used_ip(used), .id_dest_ip(dest), .id_wen_ip(wen), .id_is_load_ip(is_load),
    .flush_ip(flush), .ext_stall_ip(ext_stall),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cnt_op(scnt1), .fwd_cnt_op(fcnt1),
`endif
    .fwd_sel_op(sel1), .stall_op(stall1)
  );

  typedef struct {
    int          dut;
    logic [7:0]  sel;
    logic        stall;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  logic chk_req = 1'b0;
  int   total = 0;
  int   bad   = 0;

  // Monitor: pops one expectation per requested check, mid-cycle.
  always @(negedge clk) begin
    if (chk_req) begin
      exp_t e;
      logic [7:0] act_sel;
      logic       act_stall;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_empty: got no expectation, want one queued");
      end else begin
        e = exp_q.pop_front();
        act_sel   = (e.dut == 0) ? {4'b0, sel0} : {2'b0, sel1};
        act_stall = (e.dut == 0) ? stall0 : stall1;
        if (act_sel !== e.sel || act_stall !== e.stall) begin
          bad++;
          $display("FAIL %s dut%0d: got sel=%h stall=%b, want sel=%h stall=%b",
                   e.name, e.dut, act_sel, act_stall, e.sel, e.stall);
        end
      end
    end
  end

  task automatic step(input int d, input logic v, input logic [4:0] s0, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [2:0] u, input logic [4:0] dst,
                      input logic we, input logic ld, input logic fl, input logic ex,
                      input logic [7:0] esel, input logic estall, input string nm);
    exp_t e;
    id_valid  = v;
    src_bus   = {s2, s1, s0};
    used      = u;
    dest      = dst;
    wen       = we;
    is_load   = ld;
    flush     = fl;
    ext_stall = ex;
    e.dut = d; e.sel = esel; e.stall = estall; e.name = nm;
    exp_q.push_back(e);
    chk_req = 1'b1;
    @(negedge clk);
    #1 chk_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string nm);
    step(0, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, nm);
  endtask

  initial begin
    rst_n = 1'b0;
    id_valid = 1'b0; src_bus = '0; used = '0; dest = '0;
    wen = 1'b0; is_load = 1'b0; flush = 1'b0; ext_stall = 1'b0;
    @(posedge clk); #1;
    step(0, 1'b1, 5'd5, 5'd5, 5'd0, 3'b011, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "reset_u0");
    step(1, 1'b1, 5'd5, 5'd5, 5'd5, 3'b111, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, "reset_u1");
    rst_n = 1'b1;

    // add x5,x1,x2 ; sub x6,x5,x5 ; or x7,x5,x0
    step(0, 1'b1, 5'd1, 5'd2, 5'd0, 3'b011, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "add_prod");
    step(0, 1'b1, 5'd5, 5'd5, 5'd0, 3'b011, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 8'h05, 1'b0, "sub_fwd1");
    step(0, 1'b1, 5'd5, 5'd0, 5'd0, 3'b011, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 1'b0, "or_fwd2");
    idle("drain_a"); idle("drain_b");

    // lw x3,0(x4) ; add x8,x3,x1
    step(0, 1'b1, 5'd4, 5'd0, 5'd0, 3'b001, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, "lw_prod");
    step(0, 1'b1, 5'd3, 5'd1, 5'd0, 3'b011, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, "loaduse_stall");
    step(0, 1'b1, 5'd3, 5'd1, 5'd0, 3'b011, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 1'b0, "loaduse_fwd2");
    idle("drain_c"); idle("drain_d");

    // addi x9 ; addi x9 ; add x10,x9,x9
    step(0, 1'b1, 5'd1, 5'd0, 5'd0, 3'b001, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "addi9_a");
    step(0, 1'b1, 5'd1, 5'd0, 5'd0, 3'b001, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "addi9_b");
    step(0, 1'b1, 5'd9, 5'd9, 5'd0, 3'b011, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 8'h05, 1'b0, "youngest_wins");
    idle("drain_e"); idle("drain_f");

    // addi x13 ; flushed add x12 ; addi x0 with unused src1=x13 ; add x16,x12,x0
    step(0, 1'b1, 5'd1, 5'd0, 5'd0, 3'b001, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "addi13");
    step(0, 1'b1, 5'd2, 5'd3, 5'd0, 3'b011, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, "flushed_prod");
    step(0, 1'b1, 5'd1, 5'd13, 5'd0, 3'b001, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "unused_src");
    step(0, 1'b1, 5'd12, 5'd0, 5'd0, 3'b011, 5'd16, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "flushed_nofwd");
    idle("drain_g"); idle("drain_h");

    // external freeze after a producer
    step(0, 1'b1, 5'd1, 5'd2, 5'd0, 3'b011, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "ext_prod");
    for (int c = 0; c < 3; c++)
      step(0, 1'b1, 5'd5, 5'd1, 5'd0, 3'b011, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, "ext_hold");
    step(0, 1'b1, 5'd5, 5'd1, 5'd0, 3'b011, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, "ext_release");
    step(0, 1'b1, 5'd5, 5'd1, 5'd0, 3'b011, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 1'b0, "ext_aged");
    idle("drain_i"); idle("drain_j");

    // stall with flush, then reset mid-stall
    step(0, 1'b1, 5'd4, 5'd0, 5'd0, 3'b001, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, "lw_prod2");
    step(0, 1'b1, 5'd3, 5'd1, 5'd0, 3'b011, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, "stall_flush");
    rst_n = 1'b0;
    step(0, 1'b1, 5'd3, 5'd1, 5'd0, 3'b011, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "rst_mid_stall");
    rst_n = 1'b1;
    step(0, 1'b1, 5'd3, 5'd1, 5'd0, 3'b011, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "post_rst");

    // depth-3 instance: load then 3-source consumer reading it on src2
    step(1, 1'b1, 5'd4, 5'd0, 5'd0, 3'b001, 5'd20, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, "u1_lw");
    step(1, 1'b1, 5'd21, 5'd22, 5'd20, 3'b111, 5'd23, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, "u1_stall_a");
    step(1, 1'b1, 5'd21, 5'd22, 5'd20, 3'b111, 5'd23, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, "u1_stall_b");
    step(1, 1'b1, 5'd21, 5'd22, 5'd20, 3'b111, 5'd23, 1'b1, 1'b0, 1'b0, 1'b0, 8'h30, 1'b0, "u1_fwd3");
`ifdef HAZARD_PERF_CNT_EN
    total++;
    if (scnt1 !== 32'd2) begin
      bad++;
      $display("FAIL u1_stall_cnt: got %0d, want 2", scnt1);
    end
    total++;
    if (fcnt1 !== 32'd1) begin
      bad++;
      $display("FAIL u1_fwd_cnt: got %0d, want 1", fcnt1);
    end
`endif
    idle("drain_k");

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover: got %0d unchecked, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and hazard controller for the 5-stage RISC-V core, sitting beside the ID/EX boundary. It replaces per-opcode forwarding decode with an internal tracker of in-flight destination registers, one entry per forwardable stage. It produces forwarding mux selects for any number of source operands and raises a load-use stall when a consumer needs load data that is not yet forwardable. Decode supplies per-source "used" flags, so the unit is opcode-agnostic.

## Interface
- NUM_SRC, 2, number of source operands per instruction (rs1, rs2, ...)
- FWD_DEPTH, 2, number of tracked stages after ID (1 = EX/MEM, 2 = MEM/WB, ...)
- LOAD_READY, 1, first tracker index (0-based) from which load data may be forwarded
- SEL_W, $clog2(FWD_DEPTH+1), width of each select field (derived, not overridden)
- clk  input  1  core clock, rising edge
- reset  input  1  asynchronous, active-low reset
- id_valid_ip  input  1  ID holds a valid instruction
- id_src_ip  input  5*NUM_SRC  packed source register addresses; src i = bits [5i+4:5i]
- id_src_used_ip  input  NUM_SRC  source i is actually read by the instruction
- id_dest_ip  input  5  destination register of the ID instruction
- id_wen_ip  input  1  ID instruction writes back (not NO_WRITEBACK)
- id_is_load_ip  input  1  ID instruction is a load
- flush_ip  input  1  kill the ID instruction (branch redirect)
- ext_stall_ip  input  1  pipeline frozen by another source
- fwd_sel_op  output  SEL_W*NUM_SRC  per-source select: 0 = register file, k = tracker entry k-1
- stall_op  output  1  load-use hazard; hold PC/IF/ID and inject a bubble

## Operation
- Tracker: FWD_DEPTH entries {valid, dest[4:0], is_load}. Entry 0 is the youngest (EX/MEM); entry FWD_DEPTH-1 is the oldest.
- Match for source i: id_src_used_ip[i] & entry.valid & entry.dest == src_i & src_i != 0.
- Select: the lowest-index matching entry wins (nearest producer). With no match, sel = 0. An unused source always gets sel = 0.
- Load-use: if the winning entry for any used source has is_load = 1 and index < LOAD_READY, then stall_op = 1 and that source's select is 0. stall_op is gated by id_valid_ip.
- advance = ~ext_stall_ip.
- On each advance edge:
  - entry[k] <= entry[k-1] for k ≥ 1.
  - entry[0] <= valid = id_valid_ip & id_wen_ip & ~stall_op & ~flush_ip & (id_dest_ip != 0), with dest and is_load copied from the ID inputs.
  - A stalled, flushed, non-writing or x0 instruction enters as a bubble (valid = 0).
- When ext_stall_ip = 1, all entries hold. Outputs are still evaluated from the held state.
- fwd_sel_op and stall_op are combinational from the tracker state and ID inputs. All tracker state is flops.

## Timing
- Reset (reset = 0, asynchronous): all entries are invalid. Consequently fwd_sel_op = 0, stall_op = 0, and, when compiled in, perf counters = 0. Reset mid-stall clears the stall on the same assertion.
- Forwarding latency: a producer in ID at cycle n is selectable by the consumer in ID at cycle n+1 (entry 0), and through cycle n+FWD_DEPTH.
- Load-use, LOAD_READY = 1: a load followed immediately by a dependent instruction gives stall_op = 1 for exactly one cycle. The next cycle selects entry 1.
- Simultaneous stall_op and flush_ip: flush wins for insertion (bubble), and stall_op is still driven.
- ext_stall_ip asserted during a load-use stall holds the stall with no tracker movement.
- A producer aged past entry FWD_DEPTH-1 drops out, and its value is read from the register file.

## Configuration
- HAZARD_PERF_CNT_EN defined adds two outputs:
  - stall_cnt_op [31:0]: counts cycles with stall_op & ~ext_stall_ip.
  - fwd_cnt_op [31:0]: counts advance cycles where id_valid_ip & ~stall_op & ~flush_ip and any select is nonzero.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: the ports and counters are absent. Forwarding and stall behaviour are identical in both cases.

## Test plan
- Default params: `add x5,x1,x2` then `sub x6,x5,x5` → second cycle, both selects = 1, stall_op = 0. One cycle later, an `or x7,x5,x0` has src0 sel = 2 and src1 sel = 0.
- `lw x3,0(x4)` then `add x8,x3,x1` → stall_op = 1 for 1 cycle with sel0 = 0. Next cycle sel0 = 2, stall_op = 0.
- Double producer: `addi x9,..` then `addi x9,..` then `add x10,x9,x9` → both selects = 1 (youngest wins).
- Writes to x0, unused sources (src1_used = 0 on addi), and flushed producers → all selects 0, no stall.
- ext_stall_ip held 3 cycles after a producer → consumer still sees sel = 1 throughout and after release. Reset asserted mid-stall → stall_op = 0 and selects = 0 immediately.
- FWD_DEPTH = 3, LOAD_READY = 2, NUM_SRC = 3: a load then a dependent 3-source op → 2 stall cycles, then sel = 3 on the matching source. With HAZARD_PERF_CNT_EN, stall_cnt_op = 2.
